instr_fetch_unit: RTL and testbench

- Fetches one variable-length x86-subset instruction from byte-wide instruction memory, starting at the current EIP.
- Decodes the instruction length as it fetches.
- Presents the instruction bytes and num_of_ope to the execute/sequencer stage, which uses num_of_ope to advance the EIP register.
- This block is the consumer of the EIP register value and the producer of its increment amount.

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's control, memory and consumer handshakes.
// The master side is the fetch unit. The slave side is the surrounding
// sequencer and the instruction memory.
interface instr_fetch_unit_if #(
   parameter int MAX_LEN = 6
);
   logic                   start;
   logic [31:0]            eip;
   logic                   flush;
   logic                   mem_rd;
   logic [31:0]            mem_addr;
   logic                   mem_valid;
   logic [7:0]             mem_rdata;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [8*MAX_LEN-1:0]   instr_bytes;
   logic [3:0]             num_of_ope;
   logic                   illegal;
   logic                   busy;

   modport master (
      input  start, eip, flush, mem_valid, mem_rdata, instr_ready,
      output mem_rd, mem_addr, instr_valid, instr_bytes, num_of_ope, illegal, busy
   );

   modport slave (
      output start, eip, flush, mem_valid, mem_rdata, instr_ready,
      input  mem_rd, mem_addr, instr_valid, instr_bytes, num_of_ope, illegal, busy
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches one variable-length x86-subset instruction a byte at a time and
// decodes its length on the fly. Every output is a register. Register next
// values are computed from the next state, so no input reaches an output
// combinationally.
module instr_fetch_unit #(
   parameter int MAX_LEN = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   instr_fetch_unit_if.master   bus
);
   localparam int         IDX_W     = 3;
   localparam logic [3:0] LEN_ILL   = 4'd0;
   localparam logic [3:0] LEN_MODRM = 4'd15;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3} state_t;

   state_t                 state_r, state_nxt_s;
   logic [31:0]            base_r, base_nxt_s;
   logic [IDX_W-1:0]       idx_r, idx_nxt_s;
   logic [3:0]             len_r, len_nxt_s;
   logic [8*MAX_LEN-1:0]   byte_buf_r, byte_buf_nxt_s;
   logic [3:0]             num_r, num_nxt_s;
   logic                   ill_r, ill_nxt_s;
   logic                   mem_rd_r, mem_rd_nxt_s;
   logic [31:0]            mem_addr_r, mem_addr_nxt_s;
   logic                   instr_valid_r, instr_valid_nxt_s;
   logic                   busy_r, busy_nxt_s;
   logic [3:0]             op_len_s, mrm_len_s, len_s;
   logic                   ill_s, done_s;

   // Length from the opcode byte. LEN_MODRM means the ModRM byte decides.
   function automatic logic [3:0] op_len(input logic [7:0] op);
      case (op) inside
         [8'h40:8'h5F], 8'h90, 8'hC3, 8'hF4:                      op_len = 4'd1;
         [8'hB0:8'hB7], 8'h04, 8'h2C, 8'h3C, 8'hEB, 8'h74, 8'h75: op_len = 4'd2;
         [8'hB8:8'hBF], 8'h05, 8'h2D, 8'h3D, 8'hE9:               op_len = 4'd5;
         8'h01, 8'h29, 8'h31, 8'h89, 8'h8B:                       op_len = LEN_MODRM;
         default:                                                 op_len = LEN_ILL;
      endcase
   endfunction

   // Length implied by a ModRM byte. SIB and disp32-only forms are not supported.
   function automatic logic [3:0] modrm_len(input logic [7:0] mrm);
      case (mrm[7:6])
         2'b11:   modrm_len = 4'd2;
         2'b01:   modrm_len = 4'd3;
         2'b10:   modrm_len = 4'd6;
         2'b00:   modrm_len = (mrm[2:1] == 2'b10) ? LEN_ILL : 4'd2;
         default: modrm_len = LEN_ILL;
      endcase
   endfunction

   // Decode the byte arriving now. len_r == 0 at idx 1 means a ModRM length is pending.
   always_comb begin
      op_len_s  = op_len(bus.mem_rdata);
      mrm_len_s = modrm_len(bus.mem_rdata);
      if (idx_r == 3'd0) begin
         ill_s = (op_len_s == LEN_ILL);
         len_s = (op_len_s == LEN_MODRM) ? 4'd0 : op_len_s;
      end else if ((idx_r == 3'd1) && (len_r == 4'd0)) begin
         ill_s = (mrm_len_s == LEN_ILL);
         len_s = mrm_len_s;
      end else begin
         ill_s = 1'b0;
         len_s = len_r;
      end
      done_s = ill_s || (({1'b0, idx_r} + 4'd1) == len_s);
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic. Flush overrides everything except reset.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = bus.start ? ST_REQ : ST_IDLE;
            ST_REQ:  state_nxt_s = ST_WAIT;
            ST_WAIT: state_nxt_s = bus.mem_valid ? (done_s ? ST_DONE : ST_REQ) : ST_WAIT;
            ST_DONE: state_nxt_s = bus.instr_ready ? ST_IDLE : ST_DONE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Next values of the fetch context: base, index, decoded length, byte buffer and result.
   always_comb begin
      base_nxt_s     = base_r;
      idx_nxt_s      = idx_r;
      len_nxt_s      = len_r;
      byte_buf_nxt_s = byte_buf_r;
      num_nxt_s      = num_r;
      ill_nxt_s      = ill_r;
      if (bus.flush) begin
         idx_nxt_s      = 3'd0;
         len_nxt_s      = 4'd0;
         byte_buf_nxt_s = '0;
         num_nxt_s      = 4'd0;
         ill_nxt_s      = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  base_nxt_s     = bus.eip;
                  idx_nxt_s      = 3'd0;
                  len_nxt_s      = 4'd0;
                  byte_buf_nxt_s = '0;
                  num_nxt_s      = 4'd0;
                  ill_nxt_s      = 1'b0;
               end else begin
                  base_nxt_s = base_r;
               end
            end
            ST_WAIT: begin
               if (bus.mem_valid) begin
                  byte_buf_nxt_s[{idx_r, 3'b000} +: 8] = bus.mem_rdata;
                  len_nxt_s = len_s;
                  if (ill_s) begin
                     ill_nxt_s = 1'b1;
                     num_nxt_s = 4'd1;
                  end else if (done_s) begin
                     num_nxt_s = len_s;
                  end else begin
                     idx_nxt_s = idx_r + 3'd1;
                  end
               end else begin
                  idx_nxt_s = idx_r;
               end
            end
            default: begin
               idx_nxt_s = idx_r;
            end
         endcase
      end
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      mem_rd_nxt_s      = (state_nxt_s == ST_REQ);
      instr_valid_nxt_s = (state_nxt_s == ST_DONE);
      busy_nxt_s        = (state_nxt_s != ST_IDLE);
      mem_addr_nxt_s    = (state_nxt_s == ST_REQ) ? (base_nxt_s + {29'd0, idx_nxt_s}) : 32'd0;
   end

   // Output and fetch-context registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         base_r        <= 32'd0;
         idx_r         <= 3'd0;
         len_r         <= 4'd0;
         byte_buf_r    <= '0;
         num_r         <= 4'd0;
         ill_r         <= 1'b0;
         mem_rd_r      <= 1'b0;
         mem_addr_r    <= 32'd0;
         instr_valid_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         base_r        <= base_nxt_s;
         idx_r         <= idx_nxt_s;
         len_r         <= len_nxt_s;
         byte_buf_r    <= byte_buf_nxt_s;
         num_r         <= num_nxt_s;
         ill_r         <= ill_nxt_s;
         mem_rd_r      <= mem_rd_nxt_s;
         mem_addr_r    <= mem_addr_nxt_s;
         instr_valid_r <= instr_valid_nxt_s;
         busy_r        <= busy_nxt_s;
      end
   end

   assign bus.mem_rd      = mem_rd_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.instr_bytes = byte_buf_r;
   assign bus.num_of_ope  = num_r;
   assign bus.illegal     = ill_r;
   assign bus.busy        = busy_r;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model with selectable
// response latency, hand-computed expectations, immediate-assertion checks.
module tb_instr_fetch_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          lat = 1;
   int          resp_cnt = 0;
   logic [7:0]  paddr = 8'd0;
   logic [7:0]  mem [0:255];
   logic [31:0] rd_q [$];

   instr_fetch_unit_if #(.MAX_LEN(6)) bus ();

   instr_fetch_unit #(.MAX_LEN(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory model: answers each read after lat cycles and logs the address.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.mem_valid <= 1'b0;
         bus.mem_rdata <= 8'd0;
         resp_cnt      <= 0;
      end else begin
         bus.mem_valid <= 1'b0;
         if (resp_cnt == 1) begin
            bus.mem_valid <= 1'b1;
            bus.mem_rdata <= mem[paddr];
            resp_cnt      <= 0;
         end else if (resp_cnt > 1) begin
            resp_cnt <= resp_cnt - 1;
         end
         if (bus.mem_rd) begin
            rd_q.push_back(bus.mem_addr);
            paddr <= bus.mem_addr[7:0];
            if (lat == 1) begin
               bus.mem_valid <= 1'b1;
               bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            end else begin
               resp_cnt <= lat - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] a);
      @(negedge clock);
      bus.eip   = a;
      bus.start = 1'b1;
      start_cyc = cyc;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(output bit found, output int vc);
      found = 1'b0;
      vc    = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (bus.instr_valid === 1'b1) begin
            found = 1'b1;
            vc    = cyc;
         end else begin
            @(negedge clock);
         end
      end
   endtask

   task automatic run_fetch(input string tag, input logic [31:0] a, input logic [47:0] exp_bytes,
                            input logic [3:0] exp_num, input logic exp_ill, input int n_reads);
      bit          found;
      int          vc;
      logic [31:0] first_a;
      logic [31:0] last_a;
      rd_q.delete();
      do_start(a);
      wait_valid(found, vc);
      first_a = (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF;
      last_a  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 32'hDEAD_BEEF;
      chk({tag, "_valid"},   {63'd0, found}, 64'd1);
      chk({tag, "_latency"}, 64'(vc - start_cyc), 64'(2 * n_reads + 1));
      chk({tag, "_num"},     {60'd0, bus.num_of_ope}, {60'd0, exp_num});
      chk({tag, "_bytes"},   {16'd0, bus.instr_bytes}, {16'd0, exp_bytes});
      chk({tag, "_illegal"}, {63'd0, bus.illegal}, {63'd0, exp_ill});
      chk({tag, "_nreads"},  64'(rd_q.size()), 64'(n_reads));
      chk({tag, "_addr0"},   {32'd0, first_a}, {32'd0, a});
      chk({tag, "_addrN"},   {32'd0, last_a}, {32'd0, a + 32'(n_reads - 1)});
      bus.instr_ready = 1'b1;
      @(negedge clock);
      bus.instr_ready = 1'b0;
      chk({tag, "_drop"},    {63'd0, bus.instr_valid}, 64'd0);
      chk({tag, "_idle"},    {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      bit          found;
      int          vc;
      bit          any_valid;
      bus.start       = 1'b0;
      bus.eip         = 32'd0;
      bus.flush       = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h0B] = 8'h90;
      mem[8'h20] = 8'hB8; mem[8'h21] = 8'h78; mem[8'h22] = 8'h56; mem[8'h23] = 8'h34; mem[8'h24] = 8'h12;
      mem[8'h30] = 8'h89; mem[8'h31] = 8'hC3;
      mem[8'h38] = 8'h89; mem[8'h39] = 8'h45; mem[8'h3A] = 8'h08;
      mem[8'h40] = 8'h89; mem[8'h41] = 8'h85; mem[8'h42] = 8'h11; mem[8'h43] = 8'h22;
      mem[8'h44] = 8'h33; mem[8'h45] = 8'h44;
      mem[8'h48] = 8'h89; mem[8'h49] = 8'h05;
      mem[8'h50] = 8'h0F;
      mem[8'hFF] = 8'hEB; mem[8'h00] = 8'h05;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_mem_rd", {63'd0, bus.mem_rd}, 64'd0);
      chk("rst_valid",  {63'd0, bus.instr_valid}, 64'd0);
      chk("rst_busy",   {63'd0, bus.busy}, 64'd0);
      chk("rst_bytes",  {16'd0, bus.instr_bytes}, 64'd0);
      chk("rst_num",    {60'd0, bus.num_of_ope}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Length classes, illegal opcodes, address wrap
      run_fetch("nop",    32'h0000_000B, 48'h90,           4'd1, 1'b0, 1);
      run_fetch("mov5",   32'h0000_0020, 48'h12_3456_78B8, 4'd5, 1'b0, 5);
      run_fetch("mrm11",  32'h0000_0030, 48'hC389,         4'd2, 1'b0, 2);
      run_fetch("mrm01",  32'h0000_0038, 48'h08_4589,      4'd3, 1'b0, 3);
      run_fetch("mrm10",  32'h0000_0040, 48'h4433_2211_8589, 4'd6, 1'b0, 6);
      run_fetch("mrmill", 32'h0000_0048, 48'h0589,         4'd1, 1'b1, 2);
      run_fetch("opill",  32'h0000_0050, 48'h0F,           4'd1, 1'b1, 1);
      run_fetch("wrap",   32'hFFFF_FFFF, 48'h05EB,         4'd2, 1'b0, 2);

      // DONE held for 10 cycles with a start pulse in the middle
      rd_q.delete();
      do_start(32'h0000_000B);
      wait_valid(found, vc);
      chk("hold_valid0", {63'd0, found}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         bus.start = (i == 3);
         bus.eip   = 32'h0000_0020;
         @(negedge clock);
         chk("hold_valid", {63'd0, bus.instr_valid}, 64'd1);
         chk("hold_bytes", {16'd0, bus.instr_bytes}, 64'h90);
         chk("hold_num",   {60'd0, bus.num_of_ope}, 64'd1);
      end
      bus.start = 1'b0;
      chk("hold_nreads", 64'(rd_q.size()), 64'd1);
      bus.instr_ready = 1'b1;
      @(negedge clock);
      bus.instr_ready = 1'b0;
      chk("hold_drop", {63'd0, bus.instr_valid}, 64'd0);

      // Flush and start together: flush wins
      rd_q.delete();
      @(negedge clock);
      bus.flush = 1'b1; bus.start = 1'b1; bus.eip = 32'h0000_0020;
      @(negedge clock);
      bus.flush = 1'b0; bus.start = 1'b0;
      @(negedge clock);
      chk("fs_busy",   {63'd0, bus.busy}, 64'd0);
      chk("fs_nreads", 64'(rd_q.size()), 64'd0);

      // Flush while waiting for byte 3 of a 5-byte instruction; data arrives a cycle later
      lat = 2;
      rd_q.delete();
      do_start(32'h0000_0020);
      for (int i = 0; i < 40 && rd_q.size() < 3; i++) @(negedge clock);
      chk("fl_reached", 64'(rd_q.size()), 64'd3);
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
      any_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         any_valid = any_valid | bus.instr_valid;
      end
      chk("fl_novalid", {63'd0, any_valid}, 64'd0);
      chk("fl_busy",    {63'd0, bus.busy}, 64'd0);
      chk("fl_bytes",   {16'd0, bus.instr_bytes}, 64'd0);
      chk("fl_nreads",  64'(rd_q.size()), 64'd3);
      lat = 1;
      run_fetch("postfl", 32'h0000_0020, 48'h12_3456_78B8, 4'd5, 1'b0, 5);

      // Asynchronous reset in the middle of REQ
      do_start(32'h0000_0020);
      chk("ar_pre_rd",   {63'd0, bus.mem_rd}, 64'd1);
      chk("ar_pre_addr", {32'd0, bus.mem_addr}, 64'h20);
      #1 reset = 1'b1;
      #1;
      chk("ar_mem_rd", {63'd0, bus.mem_rd}, 64'd0);
      chk("ar_addr",   {32'd0, bus.mem_addr}, 64'd0);
      chk("ar_busy",   {63'd0, bus.busy}, 64'd0);
      chk("ar_bytes",  {16'd0, bus.instr_bytes}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_fetch("postrst", 32'h0000_000B, 48'h90, 4'd1, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
